frame_draw_ctrl: RTL
====================

Name: frame_draw_ctrl

Overview:
- Per-frame draw scheduler. Sits between the background map drawer, N sprite drawers and the single VGA memory write port.
- On each frame tick it enables the map drawer until it reports done, then each sprite drawer in index order.
- Muxes the active client's x/y/colour/write onto the VGA port and reports frame completion and overruns to game control.

Parameters:
- N_SPR, 4, number of sprite drawer clients (1..8).
- TIMEOUT, 17'd80000, max cycles any client may stay enabled without asserting done.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse requesting a new frame draw.
- map_done  in  1  done from map drawer.
- map_x  in  9; map_y  in  8; map_colour  in  6; map_write  in  1  map drawer outputs.
- map_enable  out  1  enable to map drawer.
- spr_done  in  N_SPR  per-sprite done.
- spr_x  in  9*N_SPR; spr_y  in  8*N_SPR; spr_colour  in  6*N_SPR; spr_write  in  N_SPR  packed sprite outputs, client i at slice i.
- spr_enable  out  N_SPR  one-hot sprite enable.
- vga_x  out  9; vga_y  out  8; vga_colour  out  6; vga_write  out  1  to VGA memory.
- busy  out  1  high from frame start until frame_done.
- frame_done  out  1  one-cycle pulse at frame end.
- overrun  out  1  sticky; a tick arrived while busy with a tick already pending.
- timeout_err  out  1  sticky; a client was aborted by the watchdog.

Behaviour:
- Reset (async, reset==0): state IDLE, all enables 0, vga_write 0, vga_x/y/colour 0, busy 0, frame_done 0, overrun 0, timeout_err 0, pending 0, sprite index 0, watchdog 0.
- Reset asserted mid-frame drops all enables immediately; after release the block waits in IDLE for a new tick.
- States: IDLE, MAP, SPR, GAP, FIN.
- IDLE: on frame_tick or pending → MAP; clear pending; busy=1.
- MAP: map_enable=1. On map_done=1 → GAP with sprite index 0. Enables deassert in the cycle after done is sampled, so done is seen for exactly one cycle of enable.
- GAP: one cycle with all enables 0, so each client returns its done low and re-arms. Then:
  - if index < N_SPR → SPR;
  - else → FIN.
- SPR: spr_enable[index]=1 (one-hot). On spr_done[index] → index+1, → GAP.
- FIN: frame_done=1 for one cycle, busy=0 → IDLE.
- Watchdog: counts cycles in MAP/SPR and clears on state entry. When it reaches TIMEOUT:
  - set timeout_err;
  - treat the current client as done (same transition as done);
  - the frame still completes.
- Only the enabled client's done is honoured; done from a disabled client is ignored.
- Mux: registered, 1-cycle latency from client outputs to vga_*.
  - vga_write = registered(selected client write AND its enable).
  - In IDLE/GAP/FIN, vga_write=0 and vga_x/y/colour hold their last values.
  - The map drawer's write in its done cycle passes through; that pixel is valid.
- frame_tick while busy:
  - pending=0 → set pending (one deep);
  - pending=1 → set overrun, drop the tick.
- A tick arriving in the FIN cycle sets pending, and MAP starts 2 cycles later via IDLE.
- frame_tick in the same cycle as reset release is ignored.
- Sticky flags clear only on reset.

Test Plan:
- Basic frame, N_SPR=2: tick at t0; map done after 10 cycles; sprites done after 5 each.
  - map_enable is high t1..t11; GAP at t12; spr_enable=01 t13..t18; GAP; spr_enable=10; frame_done pulses once; busy is low after it.
  - Total enabled/gap sequence matches exactly.
- Mux: map drives x=5, y=7, colour=6'h2A, write=1 while enabled → vga_x=5, vga_y=7, vga_colour=2A, vga_write=1 one cycle later. A sprite asserting write while not enabled gives vga_write=0.
- Pending/overrun: two ticks during MAP → pending set, overrun=1. After frame_done the second frame starts automatically; no third frame occurs.
- Timeout with TIMEOUT=20: sprite 0 never asserts done → spr_enable[0] drops after 20 cycles, timeout_err=1, sprite 1 is still drawn, frame_done pulses.
- Spurious done: spr_done[1]=1 during MAP → ignored; order is unchanged.
- Reset mid-SPR: reset low for 1 cycle → all enables and vga_write drop asynchronously, busy=0. No frame starts until the next tick.

Source files
------------

// File: rtl/frame_draw_ctrl.sv
// Per-frame draw scheduler: runs the map drawer, then each sprite drawer in index order,
// onto the single VGA write port. A per-client watchdog keeps a stuck client from stalling the frame.
module frame_draw_ctrl #(
    parameter int          N_SPR   = 4,
    parameter logic [16:0] TIMEOUT = 17'd80000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 map_done,
    input  logic [8:0]           map_x,
    input  logic [7:0]           map_y,
    input  logic [5:0]           map_colour,
    input  logic                 map_write,
    output logic                 map_enable,
    input  logic [N_SPR-1:0]     spr_done,
    input  logic [9*N_SPR-1:0]   spr_x,
    input  logic [8*N_SPR-1:0]   spr_y,
    input  logic [6*N_SPR-1:0]   spr_colour,
    input  logic [N_SPR-1:0]     spr_write,
    output logic [N_SPR-1:0]     spr_enable,
    output logic [8:0]           vga_x,
    output logic [7:0]           vga_y,
    output logic [5:0]           vga_colour,
    output logic                 vga_write,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun,
    output logic                 timeout_err
);

    localparam int IW = $clog2(N_SPR + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAP  = 3'd1,
        S_SPR  = 3'd2,
        S_GAP  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   idx_r;
    logic [16:0]     wd_r;
    logic            pending_r;
    logic            armed_r;

    logic [8:0]       sel_x_s;
    logic [7:0]       sel_y_s;
    logic [5:0]       sel_c_s;
    logic             sel_w_s;
    logic             sel_done_s;
    logic [N_SPR-1:0] onehot_s;
    logic             tick_s;
    logic             in_client_s;
    logic             client_done_s;
    logic             wd_hit_s;
    logic             advance_s;

    // A tick in the first cycle after reset release is dropped (armed_r is still 0).
    assign tick_s      = frame_tick & armed_r;
    assign in_client_s = (state_r == S_MAP) || (state_r == S_SPR);
    assign wd_hit_s    = (wd_r == (TIMEOUT - 17'd1));
    assign advance_s   = in_client_s & (client_done_s | wd_hit_s);

    // Decode the sprite index and AND-OR select that sprite's outputs and done.
    always_comb begin
        sel_x_s    = 9'd0;
        sel_y_s    = 8'd0;
        sel_c_s    = 6'd0;
        sel_w_s    = 1'b0;
        sel_done_s = 1'b0;
        onehot_s   = {N_SPR{1'b0}};
        for (int i = 0; i < N_SPR; i++) begin
            onehot_s[i] = (idx_r == IW'(i));
            sel_x_s     = sel_x_s | (spr_x[i*9 +: 9] & {9{onehot_s[i]}});
            sel_y_s     = sel_y_s | (spr_y[i*8 +: 8] & {8{onehot_s[i]}});
            sel_c_s     = sel_c_s | (spr_colour[i*6 +: 6] & {6{onehot_s[i]}});
            sel_w_s     = sel_w_s | (spr_write[i] & onehot_s[i]);
            sel_done_s  = sel_done_s | (spr_done[i] & onehot_s[i]);
        end
    end

    // Only the currently enabled client's done is honoured.
    always_comb begin
        client_done_s = 1'b0;
        case (state_r)
            S_MAP:   client_done_s = map_done;
            S_SPR:   client_done_s = sel_done_s;
            default: client_done_s = 1'b0;
        endcase
    end

    // Frame sequencer, watchdog, tick queueing and sticky error flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            idx_r       <= {IW{1'b0}};
            wd_r        <= 17'd0;
            pending_r   <= 1'b0;
            armed_r     <= 1'b0;
            map_enable  <= 1'b0;
            spr_enable  <= {N_SPR{1'b0}};
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            armed_r    <= 1'b1;
            frame_done <= 1'b0;
            // Ticks during a frame (FIN included) queue one deep; a second one is an overrun.
            if (tick_s && (state_r != S_IDLE)) begin
                if (pending_r) begin
                    overrun <= 1'b1;
                end else begin
                    pending_r <= 1'b1;
                end
            end
            case (state_r)
                S_IDLE: begin
                    wd_r <= 17'd0;
                    if (tick_s || pending_r) begin
                        state_r    <= S_MAP;
                        pending_r  <= 1'b0;
                        busy       <= 1'b1;
                        map_enable <= 1'b1;
                        idx_r      <= {IW{1'b0}};
                    end
                end
                S_MAP, S_SPR: begin
                    if (advance_s) begin
                        state_r    <= S_GAP;
                        map_enable <= 1'b0;
                        spr_enable <= {N_SPR{1'b0}};
                        wd_r       <= 17'd0;
                        idx_r      <= (state_r == S_SPR) ? (idx_r + IW'(1)) : {IW{1'b0}};
                        if (!client_done_s) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        wd_r <= wd_r + 17'd1;
                    end
                end
                S_GAP: begin
                    if (idx_r < IW'(N_SPR)) begin
                        state_r    <= S_SPR;
                        spr_enable <= onehot_s;
                        wd_r       <= 17'd0;
                    end else begin
                        state_r    <= S_FIN;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                S_FIN: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r    <= S_IDLE;
                    map_enable <= 1'b0;
                    spr_enable <= {N_SPR{1'b0}};
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Registered pixel mux; coordinates hold whenever no client is enabled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vga_x      <= 9'd0;
            vga_y      <= 8'd0;
            vga_colour <= 6'd0;
            vga_write  <= 1'b0;
        end else if (map_enable) begin
            vga_x      <= map_x;
            vga_y      <= map_y;
            vga_colour <= map_colour;
            vga_write  <= map_write;
        end else if (|spr_enable) begin
            vga_x      <= sel_x_s;
            vga_y      <= sel_y_s;
            vga_colour <= sel_c_s;
            vga_write  <= sel_w_s;
        end else begin
            vga_write  <= 1'b0;
        end
    end

endmodule
